// File: rtl/mem_responder.sv
// mem_responder: single-outstanding request/response memory slave with a
// fixed, parameterised access latency.
//
// A request is accepted in IDLE, waits WAIT_CYCLES cycles in WAIT, and the
// access commits on the edge that enters RESP. The response is held in RESP
// until the requester takes it. Addresses at or above MEM_DEPTH return an
// error and leave memory untouched. The memory array is never reset.
//
// Ports
//   clk        : clock, all logic on the rising edge
//   rst        : synchronous active-high reset
//   req_valid  : request present
//   req_ready  : request can be accepted (IDLE only)
//   req_we     : 1 = write, 0 = read
//   req_addr   : word address
//   req_wdata  : write data
//   req_be     : byte enables, bit1 = [15:8], bit0 = [7:0]
//   rsp_valid  : response present (RESP only)
//   rsp_ready  : requester accepts the response
//   rsp_rdata  : read data (0 for writes and errors)
//   rsp_err    : address was out of range
module mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int MEM_DEPTH   = 192,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_wdata,
  input  logic [1:0]        req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [15:0]       rsp_rdata,
  output logic              rsp_err
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0]      CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam logic [ADDR_W:0] DEPTH    = (ADDR_W + 1)'(MEM_DEPTH);

  state_t              state;
  logic [3:0]          cnt;
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_addr;
  logic [15:0]         lat_wdata;
  logic [1:0]          lat_be;

  logic [15:0]         mem [0:MEM_DEPTH-1];

  logic                acc_we;
  logic [ADDR_W-1:0]   acc_addr;
  logic [15:0]         acc_wdata;
  logic [1:0]          acc_be;
  logic                in_range;
  logic                commit;
  logic                wr_en;

  // With zero wait the access commits on the accept edge itself, so the
  // request inputs are used directly; otherwise the latched copy is used.
  always_comb begin
    if (WAIT_CYCLES == 0) begin
      acc_we    = req_we;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_be    = req_be;
    end else begin
      acc_we    = lat_we;
      acc_addr  = lat_addr;
      acc_wdata = lat_wdata;
      acc_be    = lat_be;
    end
    in_range = ({1'b0, acc_addr} < DEPTH);
    commit   = !rst && (((state == WAIT) && (cnt == 4'd0)) ||
                        ((WAIT_CYCLES == 0) && (state == IDLE) && req_valid));
    wr_en    = commit && acc_we && in_range;
  end

  assign req_ready = (state == IDLE) && !rst;
  assign rsp_valid = (state == RESP);

  // Array write port: no reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (acc_be[0]) mem[acc_addr][7:0]  <= acc_wdata[7:0];
      if (acc_be[1]) mem[acc_addr][15:8] <= acc_wdata[15:8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_be    <= req_be;
            if (WAIT_CYCLES == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= CNT_LOAD;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= RESP;
          else             cnt   <= cnt - 4'd1;
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // Read port: the array value sampled here predates any write on this edge.
      if (commit) begin
        rsp_err   <= !in_range;
        rsp_rdata <= (!acc_we && in_range) ? mem[acc_addr] : '0;
      end
    end
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_W, default 8: word-address width.
REQ-002 Parameter MEM_DEPTH, default 192: number of implemented 16-bit words, 1..2^ADDR_W.
REQ-003 Parameter WAIT_CYCLES, default 2: added access latency, 0..15.
REQ-004 Port clk, input, 1: single clock; all logic on rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port req_valid, input, 1: CPU request present.
REQ-007 Port req_ready, output, 1: responder can accept a request.
REQ-008 Port req_we, input, 1: 1 = write, 0 = read.
REQ-009 Port req_addr, input, ADDR_W: word address.
REQ-010 Port req_wdata, input, 16: write data.
REQ-011 Port req_be, input, 2: byte enables; bit1 = [15:8], bit0 = [7:0].
REQ-012 Port rsp_valid, output, 1: response present.
REQ-013 Port rsp_ready, input, 1: CPU accepts the response.
REQ-014 Port rsp_rdata, output, 16: read data.
REQ-015 Port rsp_err, output, 1: address was out of range.

Function
REQ-016 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-017 req_ready SHALL be 1 only in IDLE; rsp_valid SHALL be 1 only in RESP.
REQ-018 A request SHALL be accepted on a clock edge where req_valid=1 and req_ready=1.
REQ-019 On acceptance the block SHALL latch we, addr, wdata and be.
REQ-020 On acceptance the FSM SHALL go to WAIT with a counter loaded to WAIT_CYCLES-1, or straight to RESP if WAIT_CYCLES=0.
REQ-021 WAIT SHALL decrement the counter each cycle and move to RESP on the edge where the counter is 0.
REQ-022 The access SHALL commit on the edge that enters RESP.
REQ-023 rsp_valid SHALL therefore rise exactly WAIT_CYCLES+1 cycles after the accept edge.
REQ-024 In-range write (addr < MEM_DEPTH): the block SHALL update only bytes whose be bit is 1, with rsp_rdata=0 and rsp_err=0.
REQ-025 A write with be=00 SHALL leave memory unchanged and still produce a response.
REQ-026 In-range read: rsp_rdata SHALL be mem[addr] as it was before the commit edge, with rsp_err=0; be SHALL be ignored for reads.
REQ-027 Out-of-range access (addr >= MEM_DEPTH): memory SHALL be unchanged, rsp_rdata=0 and rsp_err=1.
REQ-028 rsp_valid, rsp_rdata and rsp_err SHALL hold stable in RESP until rsp_ready=1.
REQ-029 On the edge where rsp_valid=1 and rsp_ready=1, the FSM SHALL return to IDLE.
REQ-030 A new request SHALL NOT be accepted in the same cycle as a response handshake, so the minimum period is WAIT_CYCLES+2 cycles per transaction.
REQ-031 req_* inputs SHALL be ignored outside IDLE; changes to them after acceptance SHALL NOT affect the transaction in flight.
REQ-032 rsp_ready SHALL be ignored outside RESP.
REQ-033 Memory contents SHALL be inferable as Spartan-3 block RAM: no reset of the array, one write port and one read port.

Reset
REQ-034 While rst=1 at an edge, the block SHALL go to IDLE, set the counter to 0, and drive rsp_valid=0, rsp_rdata=0 and rsp_err=0.
REQ-035 req_ready SHALL be 0 while rst=1 and SHALL be 1 on the first cycle after rst is deasserted.
REQ-036 A reset in WAIT SHALL abort the transaction with no memory write.
REQ-037 A reset in RESP SHALL discard the pending response; memory already committed SHALL keep the write.
REQ-038 Memory contents SHALL NOT be changed by reset.

Verification
REQ-039 With WAIT_CYCLES=2: write addr 0x05, data 0xA5C3, be=11, accept at cycle t -> rsp_valid=1 at t+3, rsp_err=0; a later read of 0x05 returns 0xA5C3.
REQ-040 After the above: write addr 0x05, data 0x1234, be=01, then read 0x05 -> 0xA534.
REQ-041 Read addr 0xC8 (200 >= 192) -> rsp_err=1 and rsp_rdata=0x0000; a read of 0x05 still returns 0xA534.
REQ-042 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_rdata and rsp_err are stable and req_ready=0; then assert rsp_ready -> IDLE next cycle with req_ready=1.
REQ-043 Assert rst during WAIT of a write of 0xFFFF to addr 0x05 -> next cycle IDLE with rsp_valid=0; a read of 0x05 returns 0xA534.
REQ-044 With WAIT_CYCLES=0: read accepted at t -> rsp_valid at t+1; back-to-back requests with rsp_ready=1 are accepted every 2 cycles.
